// File: rtl/seg_pkg.sv
// Shared constants and types for the multiplexed 7-segment scan decoder.
package seg_pkg;

    localparam int unsigned NUM_DIGITS = 8;
    localparam int unsigned CODE_W     = 4;
    localparam int unsigned CNT_W      = 8;

    // Bit positions inside the 8-bit seg_n bus
    localparam int unsigned SEG_A  = 7;
    localparam int unsigned SEG_B  = 6;
    localparam int unsigned SEG_C  = 5;
    localparam int unsigned SEG_D  = 4;
    localparam int unsigned SEG_E  = 3;
    localparam int unsigned SEG_F  = 2;
    localparam int unsigned SEG_G  = 1;
    localparam int unsigned SEG_DP = 0;

    // Active-high a..g glyphs, a in the MSB
    localparam logic [6:0] GLYPH_0 = 7'b1111110;
    localparam logic [6:0] GLYPH_1 = 7'b0110000;
    localparam logic [6:0] GLYPH_2 = 7'b1101101;
    localparam logic [6:0] GLYPH_3 = 7'b1111001;
    localparam logic [6:0] GLYPH_4 = 7'b0110011;
    localparam logic [6:0] GLYPH_5 = 7'b1011011;
    localparam logic [6:0] GLYPH_6 = 7'b1011111;
    localparam logic [6:0] GLYPH_7 = 7'b1110000;
    localparam logic [6:0] GLYPH_8 = 7'b1111111;
    localparam logic [6:0] GLYPH_9 = 7'b1111011;

    localparam logic [CODE_W-1:0] CODE_BLANK = 4'hF;
    localparam logic [CODE_W-1:0] CODE_ERR   = 4'hE;

    typedef enum logic {
        FRAME_EMPTY = 1'b0,
        FRAME_HELD  = 1'b1
    } frame_state_e;

    // Position of the lowest low bit of an active-low enable vector
    function automatic logic [2:0] low_index(input logic [NUM_DIGITS-1:0] an);
        low_index = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (!an[i]) low_index = 3'(i);
        end
    endfunction

endpackage

// File: rtl/seg8bcd.sv
// Combinational glyph-to-code decoder for one 7-segment digit.
module seg8bcd
    import seg_pkg::*;
(
    input  logic [6:0]        seg,
    output logic [CODE_W-1:0] code,
    output logic              err
);

    always_comb begin
        code = CODE_ERR;
        err  = 1'b1;
        case (seg)
            GLYPH_0: begin code = 4'd0; err = 1'b0; end
            GLYPH_1: begin code = 4'd1; err = 1'b0; end
            GLYPH_2: begin code = 4'd2; err = 1'b0; end
            GLYPH_3: begin code = 4'd3; err = 1'b0; end
            GLYPH_4: begin code = 4'd4; err = 1'b0; end
            GLYPH_5: begin code = 4'd5; err = 1'b0; end
            GLYPH_6: begin code = 4'd6; err = 1'b0; end
            GLYPH_7: begin code = 4'd7; err = 1'b0; end
            GLYPH_8: begin code = 4'd8; err = 1'b0; end
            GLYPH_9: begin code = 4'd9; err = 1'b0; end
            7'h00:   begin code = CODE_BLANK; err = 1'b0; end
            default: ;
        endcase
    end

endmodule

// File: rtl/seg8_scan_decoder.sv
// Recovers an 8-digit frame from a scanned 7-segment display bus and hands it
// to a consumer over a valid/ready handshake.
module seg8_scan_decoder
    import seg_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [7:0]                   seg_n,
    input  logic [NUM_DIGITS-1:0]        an_n,
    input  logic                         out_ready,
    output logic                         out_valid,
    output logic [NUM_DIGITS*CODE_W-1:0] out_bcd,
    output logic [NUM_DIGITS-1:0]        out_dp,
    output logic [NUM_DIGITS-1:0]        out_err,
    output logic                         overrun
);

    localparam logic [CNT_W-1:0] CAPTURE_AT = CNT_W'(STABLE_CYCLES - 2);
    localparam int unsigned      BCD_W      = NUM_DIGITS * CODE_W;

    logic [7:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [NUM_DIGITS-1:0] mask_q, mask_d;
    logic [BCD_W-1:0]      shadow_bcd_q, shadow_bcd_d;
    logic [NUM_DIGITS-1:0] shadow_dp_q, shadow_dp_d;
    logic [NUM_DIGITS-1:0] shadow_err_q, shadow_err_d;
    logic [BCD_W-1:0]      out_bcd_q, out_bcd_d;
    logic [NUM_DIGITS-1:0] out_dp_q, out_dp_d;
    logic [NUM_DIGITS-1:0] out_err_q, out_err_d;
    logic                  overrun_q, overrun_d;
    frame_state_e          state_q, state_d;

    logic [6:0]        seg_act;
    logic [CODE_W-1:0] dec_code;
    logic              dec_err;
    logic              stable;
    logic              capture;
    logic              complete;
    logic [2:0]        digit;

    assign seg_act = ~seg_q[SEG_A:SEG_G];

    seg8bcd u_dec (
        .seg  (seg_act),
        .code (dec_code),
        .err  (dec_err)
    );

    always_comb begin
        seg_d        = seg_n;
        an_d         = an_n;
        cnt_d        = cnt_q;
        mask_d       = mask_q;
        shadow_bcd_d = shadow_bcd_q;
        shadow_dp_d  = shadow_dp_q;
        shadow_err_d = shadow_err_q;
        out_bcd_d    = out_bcd_q;
        out_dp_d     = out_dp_q;
        out_err_d    = out_err_q;
        overrun_d    = 1'b0;
        state_d      = state_q;
        complete     = 1'b0;
        digit        = low_index(an_q);

        // Stability filter: run length of identical samples, saturating
        stable = (seg_n == seg_q) && (an_n == an_q);
        if (!stable) begin
            cnt_d = '0;
        end else if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // Capture once per stable period, only with exactly one digit enabled
        capture = stable && (cnt_q == CAPTURE_AT) && $onehot(~an_q);
        if (capture) begin
            shadow_bcd_d[{digit, 2'b00} +: CODE_W] = dec_code;
            shadow_dp_d[digit]                     = ~seg_q[SEG_DP];
            shadow_err_d[digit]                    = dec_err;
            mask_d                                 = mask_q | (NUM_DIGITS'(1) << digit);
            complete                               = (mask_d == {NUM_DIGITS{1'b1}});
        end

        // Output handshake; a completed frame always wins over the old one
        if (complete) begin
            mask_d    = '0;
            out_bcd_d = shadow_bcd_d;
            out_dp_d  = shadow_dp_d;
            out_err_d = shadow_err_d;
            overrun_d = (state_q == FRAME_HELD) && !out_ready;
            state_d   = FRAME_HELD;
        end else if ((state_q == FRAME_HELD) && out_ready) begin
            state_d = FRAME_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q        <= 8'hFF;
            an_q         <= {NUM_DIGITS{1'b1}};
            cnt_q        <= '0;
            mask_q       <= '0;
            shadow_bcd_q <= '0;
            shadow_dp_q  <= '0;
            shadow_err_q <= '0;
            out_bcd_q    <= '0;
            out_dp_q     <= '0;
            out_err_q    <= '0;
            overrun_q    <= 1'b0;
            state_q      <= FRAME_EMPTY;
        end else begin
            seg_q        <= seg_d;
            an_q         <= an_d;
            cnt_q        <= cnt_d;
            mask_q       <= mask_d;
            shadow_bcd_q <= shadow_bcd_d;
            shadow_dp_q  <= shadow_dp_d;
            shadow_err_q <= shadow_err_d;
            out_bcd_q    <= out_bcd_d;
            out_dp_q     <= out_dp_d;
            out_err_q    <= out_err_d;
            overrun_q    <= overrun_d;
            state_q      <= state_d;
        end
    end

    assign out_valid = (state_q == FRAME_HELD);
    assign out_bcd   = out_bcd_q;
    assign out_dp    = out_dp_q;
    assign out_err   = out_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_seg8_scan_decoder.sv
// Bench for seg8_scan_decoder: directed scan scenarios plus random scanning,
// every cycle compared against a run-length based frame model.
module tb_seg8_scan_decoder;

    localparam int STABLE = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  seg_n = 8'hFF;
    logic [7:0]  an_n = 8'hFF;
    logic        out_ready = 1'b1;
    logic        out_valid;
    logic [31:0] out_bcd;
    logic [7:0]  out_dp;
    logic [7:0]  out_err;
    logic        overrun;

    seg8_scan_decoder #(.STABLE_CYCLES(STABLE)) dut (
        .clk       (clk),
        .rst       (rst),
        .seg_n     (seg_n),
        .an_n      (an_n),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_bcd   (out_bcd),
        .out_dp    (out_dp),
        .out_err   (out_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    logic [6:0] glyph_tbl [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                                   7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [7:0]  m_last_seg, m_last_an;
    int          m_run;
    bit          m_have [8];
    int          m_code [8];
    bit          m_sdp  [8];
    bit          m_serr [8];
    bit          m_valid, m_overrun;
    logic [31:0] m_bcd;
    logic [7:0]  m_dp, m_err;

    // Observations for directed checks
    int          valid_seen, ovr_seen;
    logic [31:0] last_bcd;
    logic [7:0]  last_dp, last_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] gseg(input int k);
        logic [6:0] g;
        g = glyph_tbl[k];
        return {~g, 1'b1};
    endfunction

    task automatic model_reset();
        m_last_seg = 8'hFF;
        m_last_an  = 8'hFF;
        m_run      = 1;
        for (int i = 0; i < 8; i++) begin
            m_have[i] = 0; m_code[i] = 0; m_sdp[i] = 0; m_serr[i] = 0;
        end
        m_valid = 0; m_overrun = 0;
        m_bcd = '0; m_dp = '0; m_err = '0;
    endtask

    // One clock edge of the behavioural model, with the inputs present before it
    task automatic model_edge(input logic [7:0] s, input logic [7:0] a,
                              input logic rdy, input logic r);
        int  lows, pos, code;
        bit  all, complete;
        logic [6:0] p;
        if (r) begin
            model_reset();
            return;
        end
        if (s == m_last_seg && a == m_last_an) begin
            if (m_run < 1000) m_run++;
        end else begin
            m_run = 1; m_last_seg = s; m_last_an = a;
        end
        m_overrun = 0;
        complete  = 0;
        lows = 0; pos = 0;
        for (int i = 0; i < 8; i++) if (a[i] == 1'b0) begin lows++; pos = i; end
        if (m_run == STABLE && lows == 1) begin
            p = ~s[7:1];
            code = 14;
            for (int k = 0; k < 10; k++) if (glyph_tbl[k] == p) code = k;
            if (p == 7'd0) code = 15;
            m_code[pos] = code;
            m_serr[pos] = (code == 14);
            m_sdp[pos]  = ~s[0];
            m_have[pos] = 1;
            all = 1;
            for (int i = 0; i < 8; i++) if (!m_have[i]) all = 0;
            complete = all;
        end
        if (complete) begin
            if (m_valid && !rdy) m_overrun = 1;
            m_valid = 1;
            for (int i = 0; i < 8; i++) begin
                m_bcd[i*4 +: 4] = 4'(m_code[i]);
                m_dp[i]  = m_sdp[i];
                m_err[i] = m_serr[i];
                m_have[i] = 0;
            end
        end else if (m_valid && rdy) begin
            m_valid = 0;
        end
    endtask

    task automatic step(input logic [7:0] s, input logic [7:0] a,
                        input logic rdy, input logic r);
        seg_n = s; an_n = a; out_ready = rdy; rst = r;
        @(posedge clk);
        model_edge(s, a, rdy, r);
        #1;
        check("valid",   32'(out_valid), 32'(m_valid));
        check("overrun", 32'(overrun),   32'(m_overrun));
        check("bcd",     out_bcd,        m_bcd);
        check("dp",      32'(out_dp),    32'(m_dp));
        check("err",     32'(out_err),   32'(m_err));
        if (out_valid === 1'b1) begin
            valid_seen++;
            last_bcd = out_bcd; last_dp = out_dp; last_err = out_err;
        end
        if (overrun === 1'b1) ovr_seen++;
    endtask

    task automatic hold(input int d, input logic [7:0] s, input int n, input logic rdy);
        logic [7:0] a;
        a = ~(8'd1 << d);
        repeat (n) step(s, a, rdy, 1'b0);
    endtask

    initial begin
        model_reset();
        valid_seen = 0; ovr_seen = 0;
        last_bcd = '0; last_dp = '0; last_err = '0;

        // Reset state
        step(8'hFF, 8'hFF, 1'b1, 1'b1);
        step(8'hFF, 8'hFF, 1'b1, 1'b1);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_bcd",   out_bcd,        32'd0);

        // Digits 0..7 show "1".."8"
        valid_seen = 0;
        for (int d = 0; d < 8; d++) hold(d, gseg(d + 1), 6, 1'b1);
        check("seq_vcnt", 32'(valid_seen), 32'd1);
        check("seq_bcd",  last_bcd,        32'h87654321);
        check("seq_err",  32'(last_err),   32'd0);

        // Digit 3 too short, then re-held
        valid_seen = 0;
        for (int d = 0; d < 8; d++) hold(d, gseg(d + 1), (d == 3) ? 2 : 6, 1'b1);
        check("short_vcnt0", 32'(valid_seen), 32'd0);
        hold(3, gseg(4), 6, 1'b1);
        check("short_vcnt1", 32'(valid_seen), 32'd1);
        check("short_bcd",   last_bcd,        32'h87654321);

        // All-on with dp, and an illegal pattern
        valid_seen = 0;
        for (int d = 0; d < 8; d++)
            hold(d, (d == 5) ? 8'h00 : (d == 2) ? 8'h6F : gseg(d + 1), 6, 1'b1);
        check("glyph_vcnt", 32'(valid_seen),    32'd1);
        check("glyph_d5",   32'(last_bcd[23:20]), 32'h8);
        check("glyph_d2",   32'(last_bcd[11:8]),  32'hE);
        check("glyph_dp",   32'(last_dp),       32'h20);
        check("glyph_err",  32'(last_err),      32'h04);

        // Two frames unaccepted
        valid_seen = 0; ovr_seen = 0;
        for (int d = 0; d < 8; d++) hold(d, gseg(d), 6, 1'b0);
        for (int d = 0; d < 8; d++) hold(d, gseg(9 - d), 6, 1'b0);
        check("ovr_valid", 32'(out_valid), 32'd1);
        check("ovr_cnt",   32'(ovr_seen),  32'd1);
        check("ovr_bcd",   out_bcd,        32'h23456789);
        step(8'hFF, 8'hFF, 1'b1, 1'b0);
        check("ovr_accept", 32'(out_valid), 32'd0);

        // Multi-digit and no-digit enables are ignored
        valid_seen = 0;
        repeat (10) step(gseg(1), 8'hFC, 1'b1, 1'b0);
        repeat (10) step(gseg(1), 8'hFF, 1'b1, 1'b0);
        for (int d = 0; d < 7; d++) hold(d, gseg(d + 1), 6, 1'b1);
        check("ign_vcnt0", 32'(valid_seen), 32'd0);
        hold(7, gseg(8), 6, 1'b1);
        check("ign_vcnt1", 32'(valid_seen), 32'd1);

        // Reset mid-frame
        valid_seen = 0;
        for (int d = 0; d < 5; d++) hold(d, gseg(d + 1), 6, 1'b1);
        step(8'hFF, 8'hFF, 1'b1, 1'b1);
        check("mrst_bcd", out_bcd,        32'd0);
        check("mrst_dp",  32'(out_dp),    32'd0);
        check("mrst_err", 32'(out_err),   32'd0);
        for (int d = 5; d < 8; d++) hold(d, gseg(d + 1), 6, 1'b1);
        check("mrst_vcnt0", 32'(valid_seen), 32'd0);
        for (int d = 0; d < 8; d++) hold(d, gseg(d + 1), 6, 1'b1);
        check("mrst_vcnt1", 32'(valid_seen), 32'd1);

        // Random scanning
        for (int h = 0; h < 400; h++) begin
            int         d, n, pick;
            logic [7:0] s, a;
            d = $urandom_range(0, 7);
            n = $urandom_range(1, 7);
            pick = $urandom_range(0, 9);
            if (pick < 7)       s = gseg($urandom_range(0, 9)) & {7'h7F, 1'($urandom_range(0, 1))};
            else if (pick == 7) s = 8'hFF;
            else                s = 8'($urandom);
            a = ~(8'd1 << d);
            if ($urandom_range(0, 9) == 0) a = 8'($urandom);
            for (int c = 0; c < n; c++)
                step(s, a, 1'($urandom_range(0, 1)), ($urandom_range(0, 299) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seg8_scan_decoder.md
SEG8_SCAN_DECODER -- requirements
Module: seg8_scan_decoder

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4: consecutive identical samples of seg_n/an_n required before a digit is captured (legal range 2..255).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port seg_n  input  8  active-low segments; bit7=a, bit6=b ... bit1=g, bit0=dp.
REQ-005 SHALL have port an_n  input  8  active-low digit enables; bit i low selects digit i.
REQ-006 SHALL have port out_ready  input  1  consumer accepts the current frame.
REQ-007 SHALL have port out_valid  output  1  a complete frame is held on the outputs.
REQ-008 SHALL have port out_bcd  output  32  digit i code in bits [4i+3:4i].
REQ-009 SHALL have port out_dp  output  8  bit i = decimal point lit on digit i.
REQ-010 SHALL have port out_err  output  8  bit i = digit i pattern was not a legal glyph.
REQ-011 SHALL have port overrun  output  1  one-cycle pulse: an unaccepted frame was overwritten.

Function
REQ-012 SHALL decode ~seg_n[7:1] (a..g, active-high) as: 1111110->0, 0110000->1, 1101101->2, 1111001->3, 0110011->4, 1011011->5, 1011111->6, 1110000->7, 1111111->8, 1111011->9.
REQ-013 SHALL decode all-segments-off (seg_n[7:1]=7'h7F) to code 4'hF with err=0 (blank digit).
REQ-014 SHALL decode any other pattern to code 4'hE with err=1; dp (seg_n[0]) never affects the code.
REQ-015 SHALL register seg_n and an_n each cycle and keep a saturating stability counter, cleared to 0 in any cycle where either input differs from its registered value.
REQ-016 SHALL capture exactly once per stable period: in the cycle the counter reaches STABLE_CYCLES-1, if an_n has exactly one bit low.
REQ-017 SHALL ignore stable periods where an_n is all-high or has two or more bits low (no capture, no error).
REQ-018 SHALL, on capture of digit i, write code, dp and err into shadow entry i and set bit i of an 8-bit collected mask; recapture of the same digit within a frame overwrites the entry.
REQ-019 SHALL, in the cycle after the capture that makes the mask 8'hFF, load shadow into out_bcd/out_dp/out_err, set out_valid=1, and clear the mask (frame completion).
REQ-020 SHALL keep outputs and out_valid stable while out_valid=1 and out_ready=0, except as in REQ-022.
REQ-021 SHALL clear out_valid the cycle after out_valid=1 and out_ready=1 with no simultaneous frame completion.
REQ-022 SHALL, on frame completion while out_valid=1: load the new frame, keep out_valid=1, and pulse overrun=1 for one cycle if out_ready=0 that cycle (no pulse if out_ready=1).
REQ-023 SHALL continue collecting the next frame into shadow regardless of out_valid.
REQ-024 SHALL have latency: new stable inputs first sampled in cycle N -> capture in cycle N+STABLE_CYCLES-1; the 8th capture in cycle M -> out_valid=1 visible in cycle M+1.

Reset
REQ-025 SHALL, with rst=1, set out_valid=0, overrun=0, out_bcd=0, out_dp=0, out_err=0, mask=0, counter=0, registered seg_n/an_n=8'hFF.
REQ-026 SHALL discard any partial frame and any pending output on reset asserted mid-operation; collection restarts from an empty mask.

Structure
REQ-027 SHALL place in shared package seg_pkg: segment bit-position constants, the ten glyph constants, CODE_BLANK=4'hF, CODE_ERR=4'hE, and the frame state type.
REQ-028 SHALL implement glyph-to-code decoding as one combinational sub-module seg8bcd (in: 7-bit active-high segments; out: 4-bit code, err).
REQ-029 SHALL hold the stability filter, shadow store, mask and output handshake in seg8_scan_decoder.

Verification
REQ-030 SHALL cover: scan digits 0..7 showing "1","2",...,"8", each held 6 cycles, out_ready=1 -> out_valid one cycle, out_bcd=32'h87654321, out_err=0.
REQ-031 SHALL cover: digit 3 held only 2 cycles (STABLE_CYCLES=4) -> no capture; frame completes only after digit 3 is re-held >=4 cycles.
REQ-032 SHALL cover: digit 5 pattern seg_n=8'h00 (all on incl. dp) and digit 2 pattern seg_n=8'h6F -> out_bcd[23:20]=8, out_dp[5]=1, out_bcd[11:8]=E, out_err=8'h04.
REQ-033 SHALL cover: two full frames with out_ready=0 -> second frame on outputs, overrun pulses one cycle, out_valid stays 1 until out_ready=1.
REQ-034 SHALL cover: an_n=8'hFC held 10 cycles and an_n=8'hFF held 10 cycles -> no capture, mask unchanged.
REQ-035 SHALL cover: rst pulsed after 5 captures -> all outputs 0, next frame needs all 8 digits before out_valid.
